// File: rtl/mo_mul_arbiter.sv
// Round-robin issue arbiter for a shared fixed-latency Montgomery multiplier.
// Tags each issue with its requester ID and routes the result back.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module mo_mul_arbiter #(
   parameter int WIDTH   = `DATA_WIDTH,
   parameter int N_REQ   = 4,
   parameter int LATENCY = WIDTH + 1,
   parameter int MAX_OUT = 4,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]       mul_a,
   output logic [WIDTH-1:0]       mul_b,
   input  logic [WIDTH-1:0]       mul_result,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   busy
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   out_cnt_q [N_REQ];
   logic [CNT_W-1:0]   out_cnt_d [N_REQ];
   logic [LATENCY-1:0] tag_v_q, tag_v_d;
   logic [ID_W-1:0]    tag_id_q [LATENCY];
   logic [ID_W-1:0]    tag_id_d [LATENCY];
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic               busy_q, busy_d;

   logic [N_REQ-1:0]   elig;
   logic [ID_W:0]      scan_sum [N_REQ];
   logic [ID_W-1:0]    scan_idx [N_REQ];
   logic               grant_any;
   logic [ID_W-1:0]    gnt_idx;
   logic               tail_v;
   logic [ID_W-1:0]    tail_id;

   // A slot retiring this cycle frees room for a same-cycle issue.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = rst_n && req_valid[i] &&
                   ((out_cnt_q[i] < CNT_W'(MAX_OUT)) || rsp_valid_q[i]);
      end
   end

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         scan_sum[k] = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         scan_idx[k] = (scan_sum[k] >= (ID_W+1)'(N_REQ))
                     ? ID_W'(scan_sum[k] - (ID_W+1)'(N_REQ))
                     : scan_sum[k][ID_W-1:0];
      end
   end

   always_comb begin
      grant_any = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_any && elig[scan_idx[k]]) begin
            grant_any = 1'b1;
            gnt_idx   = scan_idx[k];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant_any && (gnt_idx == ID_W'(i));
      end
   end

   assign mul_a = grant_any ? req_a[gnt_idx*WIDTH +: WIDTH] : '0;
   assign mul_b = grant_any ? req_b[gnt_idx*WIDTH +: WIDTH] : '0;

   assign tail_v  = tag_v_q[LATENCY-1];
   assign tail_id = tag_id_q[LATENCY-1];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      tag_v_d     = {tag_v_q[LATENCY-2:0], grant_any};
      tag_id_d[0] = gnt_idx;
      for (int k = 1; k < LATENCY; k++) begin
         tag_id_d[k] = tag_id_q[k-1];
      end
      rsp_valid_d = tail_v ? (N_REQ'(1) << tail_id) : '0;
      rsp_id_d    = tail_id;
      rsp_data_d  = tail_v ? mul_result : rsp_data_q;
      busy_d      = (|tag_v_q) || (|rsp_valid_q);
      for (int i = 0; i < N_REQ; i++) begin
         out_cnt_d[i] = out_cnt_q[i] + CNT_W'(req_ready[i])
                        - CNT_W'(rsp_valid_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         tag_v_q     <= '0;
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= '0;
         for (int k = 0; k < LATENCY; k++) tag_id_q[k] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         tag_v_q     <= tag_v_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
         for (int k = 0; k < LATENCY; k++) tag_id_q[k] <= tag_id_d[k];
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

   for (genvar g = 0; g < N_REQ; g++) begin : g_chk
      a_cap : assert property (@(posedge clk) disable iff (!rst_n)
         out_cnt_q[g] <= CNT_W'(MAX_OUT));
      a_udf : assert property (@(posedge clk) disable iff (!rst_n)
         !(rsp_valid_q[g] && (out_cnt_q[g] == '0)));
   end

endmodule
